hamming_checker: RTL

HAMMING_CHECKER -- requirements
Module: hamming_checker

---
 rtl/hamming_checker_if.sv | 30 +++
 rtl/hamming_checker.sv | 110 +++++++++++
 2 files changed

// File: rtl/hamming_checker_if.sv
// Stream bundle for the Hamming(7,4) checker: codeword in, decoded word out,
// plus the statistics counters and their clear.
interface hamming_checker_if #(
  parameter int CNT_BITS = 16
) ();

  logic [6:0]          data_in;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          data_out;
  logic [2:0]          syndrome;
  logic                corrected;
  logic                out_valid;
  logic                out_ready;
  logic                cnt_clr;
  logic [CNT_BITS-1:0] word_cnt;
  logic [CNT_BITS-1:0] err_cnt;

  // The producer/consumer side that drives codewords and accepts results
  modport master (
    output data_in, in_valid, out_ready, cnt_clr,
    input  in_ready, data_out, syndrome, corrected, out_valid, word_cnt, err_cnt
  );

  modport slave (
    input  data_in, in_valid, out_ready, cnt_clr,
    output in_ready, data_out, syndrome, corrected, out_valid, word_cnt, err_cnt
  );

endinterface

// File: rtl/hamming_checker.sv
// Two-stage Hamming(7,4) decoder with valid/ready flow control and
// saturating word/error statistics counters.
module hamming_checker #(
  parameter int CNT_BITS   = 16,
  parameter bit CORRECT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  hamming_checker_if.slave bus
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic                s1_valid;
  logic [6:0]          s1_code;
  logic [2:0]          s1_syn;
  logic                s2_valid;
  logic [3:0]          s2_data;
  logic [2:0]          s2_syn;
  logic                s2_corr;
  logic [CNT_BITS-1:0] word_cnt;
  logic [CNT_BITS-1:0] err_cnt;

  logic                s1_adv;
  logic                s2_adv;
  logic                in_xfer;
  logic                out_xfer;
  logic [2:0]          syn_in;
  logic [3:0]          flip;
  logic [3:0]          raw_data;
  logic [3:0]          fixed_data;

  // Each stage moves when its successor can take the word or it holds nothing
  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_xfer  = bus.in_valid && s1_adv;
  assign out_xfer = s2_valid && bus.out_ready;

  always_comb begin
    syn_in[0] = bus.data_in[3] ^ bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[4];
    syn_in[1] = bus.data_in[5] ^ bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[4];
    syn_in[2] = bus.data_in[6] ^ bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[4];
  end

  // Parity-bit syndromes (001, 010, 100) leave the data nibble untouched
  always_comb begin
    flip = 4'b0000;
    case (s1_syn)
      3'b011:  flip = 4'b0001;
      3'b101:  flip = 4'b0010;
      3'b110:  flip = 4'b0100;
      3'b111:  flip = 4'b1000;
      default: flip = 4'b0000;
    endcase
  end

  assign raw_data   = {s1_code[4], s1_code[2], s1_code[1], s1_code[0]};
  assign fixed_data = CORRECT_EN ? (raw_data ^ flip) : raw_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= 7'd0;
      s1_syn   <= 3'd0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (in_xfer) begin
        s1_code <= bus.data_in;
        s1_syn  <= syn_in;
      end
    end
  end

  // Output registers only load on a real word, so they hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= 4'd0;
      s2_syn   <= 3'd0;
      s2_corr  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fixed_data;
        s2_syn  <= s1_syn;
        s2_corr <= |s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_xfer) begin
      if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_ONE;
      if (s2_corr && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_ONE;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.data_out  = s2_data;
  assign bus.syndrome  = s2_syn;
  assign bus.corrected = s2_corr;
  assign bus.word_cnt  = word_cnt;
  assign bus.err_cnt   = err_cnt;

endmodule
